// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the bit-serial ALU and its 1-bit slice.
package alu_pkg;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/ALU_1_bit.sv
// One-bit ALU slice: optional operand inversion, AND/OR/ADD selection, full-adder carry.
module ALU_1_bit
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic [1:0] operation,
  output logic       result,
  output logic       carry_out
);

  logic a_s;
  logic b_s;

  // Carry is produced for every opcode so the serial carry flop always tracks the adder chain.
  always_comb begin
    a_s       = a ^ ainvert;
    b_s       = b ^ binvert;
    carry_out = (a_s & b_s) | (carry_in & (a_s ^ b_s));
    case (operation)
      ALU_AND: result = a_s & b_s;
      ALU_OR:  result = a_s | b_s;
      ALU_ADD: result = a_s ^ b_s ^ carry_in;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_bit_serial.sv
// Bit-serial ALU: a single ALU_1_bit slice reused LSB-first over WIDTH cycles,
// with valid/ready handshakes on both the operand and result sides.
module alu_bit_serial
  import alu_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [3:0]       op_r;
  logic             carry_r;
  logic             cin_msb_r;
  logic [WIDTH-1:0] shift_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_out_r;
  logic             zero_r;
  logic             overflow_r;
  logic             slice_res_s;
  logic             slice_cout_s;

  ALU_1_bit u_slice (
    .a         (a_r[0]),
    .b         (b_r[0]),
    .carry_in  (carry_r),
    .ainvert   (op_r[3]),
    .binvert   (op_r[2]),
    .operation (op_r[1:0]),
    .result    (slice_res_s),
    .carry_out (slice_cout_s)
  );

  // FSM, operand shifters, carry flop and the output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      op_r        <= 4'b0000;
      carry_r     <= 1'b0;
      cin_msb_r   <= 1'b0;
      shift_r     <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      carry_out_r <= 1'b0;
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            op_r       <= alu_op;
            carry_r    <= carry_in;
            cnt_r      <= '0;
            shift_r    <= '0;
            in_ready_r <= 1'b0;
            state_r    <= S_RUN;
          end
        end
        S_RUN: begin
          a_r     <= a_r >> 1;
          b_r     <= b_r >> 1;
          shift_r <= {slice_res_s, shift_r[WIDTH-1:1]};
          carry_r <= slice_cout_s;
          if (cnt_r == LAST_BIT) begin
            cin_msb_r <= carry_r;
            cnt_r     <= '0;
            state_r   <= S_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_DONE: begin
          // First DONE cycle publishes the flags, derived from the completed shift register.
          if (!out_valid_r) begin
            result_r    <= shift_r;
            carry_out_r <= carry_r;
            zero_r      <= (shift_r == {WIDTH{1'b0}});
            overflow_r  <= (op_r[1:0] == ALU_ADD) ? (cin_msb_r ^ carry_r) : 1'b0;
            out_valid_r <= 1'b1;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= S_IDLE;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign carry_out = carry_out_r;
  assign zero      = zero_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_alu_bit_serial.sv
// Self-checking bench for alu_bit_serial (WIDTH=6): directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_alu_bit_serial;
  import alu_pkg::*;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic [3:0]   alu_op = 4'b0000;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] e_res;
  logic         e_co;
  logic         e_z;
  logic         e_ov;

  alu_bit_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the (optionally inverted) operands.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mcin, input logic [3:0] mop);
    logic [W-1:0] aa;
    logic [W-1:0] bb;
    logic [W:0]   sum;
    logic [W-1:0] low;
    aa  = mop[3] ? ~ma : ma;
    bb  = mop[2] ? ~mb : mb;
    sum = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, mcin};
    low = {1'b0, aa[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, mcin};
    case (mop[1:0])
      2'b00:   e_res = aa & bb;
      2'b01:   e_res = aa | bb;
      2'b10:   e_res = sum[W-1:0];
      default: e_res = '0;
    endcase
    e_co = sum[W];
    e_z  = (e_res == '0);
    e_ov = (mop[1:0] == 2'b10) ? (low[W-1] ^ sum[W]) : 1'b0;
  endfunction

  // Counts edges after the accept edge until out_valid; expects WIDTH+1.
  task automatic wait_out(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, W + 1);
  endtask

  task automatic check_out(input string tag);
    chk({tag, "_result"}, result, e_res);
    chk({tag, "_cout"}, carry_out, e_co);
    chk({tag, "_zero"}, zero, e_z);
    chk({tag, "_ovf"}, overflow, e_ov);
  endtask

  task automatic issue(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tcin, input logic [3:0] top);
    int k;
    k = 0;
    while (!in_ready && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    model(ta, tb, tcin, top);
    a = ta; b = tb; carry_in = tcin; alu_op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(tag);
  endtask

  task automatic release_out(input string tag, input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 1'b0);
    chk({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  task automatic run(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                     input logic tcin, input logic [3:0] top);
    issue(tag, ta, tb, tcin, top);
    check_out(tag);
    release_out(tag, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 0);
    chk("rst_cout", carry_out, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run("add13_22", 6'd13, 6'd22, 1'b0, 4'b0010);
    chk("add13_22_spec_ovf", e_ov, 1'b1);
    run("sub20_20", 6'd20, 6'd20, 1'b1, OP_SUB);
    run("add63_1", 6'd63, 6'd1, 1'b0, 4'b0010);
    run("add31_1", 6'd31, 6'd1, 1'b0, 4'b0010);
    run("nor0_0", 6'd0, 6'd0, 1'b0, OP_NOR);
    run("and42_15", 6'd42, 6'd15, 1'b0, 4'b0000);
    run("or42_15", 6'd42, 6'd15, 1'b0, 4'b0001);
    run("op11", 6'd42, 6'd15, 1'b1, 4'b0011);

    // Backpressure: DONE holds with new operands offered
    issue("bp", 6'd5, 6'd9, 1'b0, 4'b0010);
    a = 6'd7; b = 6'd3; carry_in = 1'b0; alu_op = 4'b0001; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check_out("bp_hold");
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_hs_valid", out_valid, 1'b0);
    chk("bp_hs_ready", in_ready, 1'b1);
    model(6'd7, 6'd3, 1'b0, 4'b0001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accepted", in_ready, 1'b0);
    wait_out("bp2");
    check_out("bp2");
    release_out("bp2", 0);

    // Reset in the middle of RUN
    a = 6'd9; b = 6'd9; carry_in = 1'b0; alu_op = 4'b0010; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, 0);
    run("after_rst", 6'd1, 6'd2, 1'b0, 4'b0010);
    chk("after_rst_spec", e_res, 3);

    // Randomized transactions with random backpressure
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic [3:0]   ro;
      ra = W'($urandom_range(0, 63));
      rb = W'($urandom_range(0, 63));
      rc = 1'($urandom_range(0, 1));
      ro = 4'($urandom_range(0, 15));
      issue("rnd", ra, rb, rc, ro);
      check_out("rnd");
      release_out("rnd", $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
